lsu_subword_rmw: RTL and testbench

//  Multi-cycle load/store unit between the core datapath and the word-only data memory.

---
 rtl/lsu_subword_rmw_if.sv | 31 +++
 rtl/lsu_subword_rmw.sv | 139 +++++++++++++
 tb/tb_lsu_subword_rmw.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_subword_rmw_if.sv
// Core-side request/response and data-memory signals of the subword load/store unit.
// The slave modport is the LSU. The master modport is its environment (core plus memory).
interface lsu_subword_rmw_if;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_write;
  logic [2:0]  lsu_req_funct3;
  logic [31:0] lsu_req_address;
  logic [31:0] lsu_req_write_data;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_read_data;
  logic        lsu_resp_fault;
  logic        data_mem_write_enable;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_write_data;
  logic [31:0] data_mem_read_data;

  modport slave (
    input  lsu_req_valid, lsu_req_write, lsu_req_funct3, lsu_req_address,
           lsu_req_write_data, data_mem_read_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_read_data, lsu_resp_fault,
           data_mem_write_enable, data_mem_address, data_mem_write_data
  );

  modport master (
    output lsu_req_valid, lsu_req_write, lsu_req_funct3, lsu_req_address,
           lsu_req_write_data, data_mem_read_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_read_data, lsu_resp_fault,
           data_mem_write_enable, data_mem_address, data_mem_write_data
  );
endinterface

// File: rtl/lsu_subword_rmw.sv
// Multi-cycle load/store unit in front of a word-only memory. It performs byte/half loads
// with extension and byte/half stores by read-modify-write, and rejects faulting requests.
module lsu_subword_rmw #(
  parameter int unsigned MEM_WORDS = 64
) (
  input logic             clk,
  input logic             reset,
  lsu_subword_rmw_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q;
  logic        req_write_q;
  logic [2:0]  req_funct3_q;
  logic [31:0] req_addr_q;
  logic [15:0] req_wdata_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_fault_q;
  logic        we_q;
  logic [31:0] wdata_q;

  function automatic logic req_fault(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [29:0] words);
    logic legal;
    logic misalign;
    if (wr) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    misalign = ((f3[1:0] == 2'b01) && addr[0]) ||
               ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    return !legal || misalign || (addr[31:2] >= words);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) r[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1])  r[31:16] = wd;
    else              r[15:0]  = wd;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      req_write_q  <= 1'b0;
      req_funct3_q <= 3'b000;
      req_addr_q   <= 32'h0;
      req_wdata_q  <= 16'h0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
    end else begin
      // Pulse-style outputs fall back to zero unless a transition below raises them.
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      unique case (state_q)
        StIdle: begin
          if (bus.lsu_req_valid) begin
            req_write_q  <= bus.lsu_req_write;
            req_funct3_q <= bus.lsu_req_funct3;
            req_addr_q   <= bus.lsu_req_address;
            req_wdata_q  <= bus.lsu_req_write_data[15:0];
            ready_q      <= 1'b0;
            if (req_fault(bus.lsu_req_write, bus.lsu_req_funct3, bus.lsu_req_address,
                          30'(MEM_WORDS))) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else if (bus.lsu_req_write && (bus.lsu_req_funct3 == 3'b010)) begin
              state_q <= StWr;
              we_q    <= 1'b1;
              wdata_q <= bus.lsu_req_write_data;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          // The word read this cycle is merged or extracted directly into the next-state regs.
          if (req_write_q) begin
            state_q <= StWr;
            we_q    <= 1'b1;
            wdata_q <= store_merge(bus.data_mem_read_data, req_wdata_q, req_funct3_q,
                                   req_addr_q[1:0]);
          end else begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_extract(bus.data_mem_read_data, req_funct3_q,
                                         req_addr_q[1:0]);
          end
        end
        StWr: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.lsu_req_ready         = ready_q;
  assign bus.lsu_resp_valid        = resp_valid_q;
  assign bus.lsu_resp_read_data    = resp_data_q;
  assign bus.lsu_resp_fault        = resp_fault_q;
  assign bus.data_mem_write_enable = we_q;
  assign bus.data_mem_address      = {req_addr_q[31:2], 2'b00};
  assign bus.data_mem_write_data   = wdata_q;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Scoreboard bench for lsu_subword_rmw: stimulus pushes expected responses, a negedge
// monitor pops and compares them, including the cycle each response appears.
module tb_lsu_subword_rmw;

  logic clk = 1'b0;
  logic reset;
  lsu_subword_rmw_if bus ();

  lsu_subword_rmw #(.MEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_count = 0;
  int          we_cyc = -1;
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus.data_mem_read_data = mem[bus.data_mem_address[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.data_mem_write_enable) mem[bus.data_mem_address[7:2]] <= bus.data_mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.data_mem_write_enable) begin
      we_count++;
      we_cyc = cyc;
      check("we_addr_align", {30'h0, bus.data_mem_address[1:0]}, 32'h0);
    end
    if (bus.lsu_resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_data", bus.lsu_resp_read_data, mon_e.data);
        check("resp_fault", {31'h0, bus.lsu_resp_fault}, {31'h0, mon_e.fault});
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Latency lat counts cycles after the accepting edge; acc is the cycle count just before it.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_fault, input int lat, input logic expect_resp,
                       input logic hold, output int acc);
    int waited = 0;
    @(negedge clk);
    bus.lsu_req_valid      = 1'b1;
    bus.lsu_req_write      = wr;
    bus.lsu_req_funct3     = f3;
    bus.lsu_req_address    = addr;
    bus.lsu_req_write_data = wdata;
    while (bus.lsu_req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.lsu_req_ready !== 1'b1) begin
      check("accept_timeout", 32'h0, 32'h1);
      acc = -1;
      bus.lsu_req_valid = 1'b0;
    end else begin
      acc = cyc;
      if (expect_resp) sb_q.push_back('{data: exp_data, fault: exp_fault, cyc: cyc + lat});
      @(posedge clk);
      #1;
      if (!hold) bus.lsu_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", sb_q.size(), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  int a1;
  int a2;
  int w0;

  initial begin
    reset                  = 1'b1;
    pre_we                 = 1'b0;
    pre_idx                = 6'h0;
    pre_data               = 32'h0;
    bus.lsu_req_valid      = 1'b0;
    bus.lsu_req_write      = 1'b0;
    bus.lsu_req_funct3     = 3'b000;
    bus.lsu_req_address    = 32'h0;
    bus.lsu_req_write_data = 32'h0;

    for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
    preload(6'd1, 32'h8899AABB);
    preload(6'd2, 32'h11223344);
    preload(6'd3, 32'h55667788);
    preload(6'd4, 32'hCAFEBABE);
    preload(6'd63, 32'h0BADF00D);

    @(negedge clk);
    check("rst_ready", {31'h0, bus.lsu_req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, bus.lsu_resp_valid}, 32'h0);
    check("rst_we", {31'h0, bus.data_mem_write_enable}, 32'h0);
    check("rst_mem_addr", bus.data_mem_address, 32'h0);
    check("rst_mem_wdata", bus.data_mem_write_data, 32'h0);
    check("rst_resp_data", bus.lsu_resp_read_data, 32'h0);
    reset = 1'b0;

    // Loads with sign/zero extension from word 1 = 8899AABB.
    issue(1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b101, 32'h6, 32'h0, 32'h00008899, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b1, 1'b0, a1);
    drain();

    // Subword stores by read-modify-write.
    w0 = we_count;
    issue(1'b1, 3'b000, 32'hA, 32'h1234565A, 32'h0, 1'b0, 3, 1'b1, 1'b0, a1);
    drain();
    check("sb_we_count", we_count - w0, 32'h1);
    check("sb_we_cycle", we_cyc, a1 + 2);
    check("sb_mem2", mem[2], 32'h115A3344);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h115A3344, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b1, 3'b001, 32'hE, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b010, 32'hC, 32'h0, 32'hBEEF7788, 1'b0, 2, 1'b1, 1'b0, a1);
    issue(1'b1, 3'b010, 32'h14, 32'h01020304, 32'h0, 1'b0, 2, 1'b1, 1'b0, a1);
    drain();
    check("sw_we_cycle", we_cyc, a1 + 1);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h01020304, 1'b0, 2, 1'b1, 1'b0, a1);
    drain();

    // Faults never touch memory; word 63 is the last legal one.
    w0 = we_count;
    issue(1'b1, 3'b010, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b1, 3'b001, 32'h103, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, a1);
    issue(1'b0, 3'b010, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0, 2, 1'b1, 1'b0, a1);
    drain();
    check("fault_no_we", we_count - w0, 32'h0);

    // Reset during the read phase of a halfword store abandons it.
    w0 = we_count;
    issue(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, 3, 1'b0, 1'b0, a1);
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'h0, bus.lsu_req_ready}, 32'h1);
    check("midrst_we", {31'h0, bus.data_mem_write_enable}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_we", we_count - w0, 32'h0);
    check("midrst_mem4", mem[4], 32'hCAFEBABE);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEBABE, 1'b0, 2, 1'b1, 1'b0, a1);
    drain();

    // Back-to-back with valid held: second accept lands the cycle after the first response.
    issue(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 1'b1, a1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, a2);
    check("b2b_accept_gap", a2 - a1, 32'h3);
    drain();

    check("final_queue_empty", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
